os2ip_arbiter: RTL and testbench

OS2IP_ARBITER -- requirements
Module: os2ip_arbiter

---
 rtl/os2ip_arbiter.sv | 151 +++++++++++++++
 tb/tb_os2ip_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os2ip_arbiter.sv
// Round-robin arbiter sharing one octet-to-integer converter between two requesters.
// Each job runs CLR -> RUN (N+1 ready cycles) -> WAIT (bounded) -> RESP.
module os2ip_arbiter #(
    parameter int unsigned DATA_BIT_WIDTH = 256,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0_valid,
    input  logic [DATA_BIT_WIDTH-1:0] req0_data,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [DATA_BIT_WIDTH-1:0] req1_data,
    output logic                      req1_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_id,
    output logic [DATA_BIT_WIDTH-1:0] resp_data,
    output logic                      resp_err,
    output logic                      conv_reset,
    output logic                      conv_ready,
    output logic [DATA_BIT_WIDTH-1:0] conv_X,
    input  logic [DATA_BIT_WIDTH-1:0] conv_x,
    input  logic                      conv_valid,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned N       = DATA_BIT_WIDTH / 8;
    localparam int unsigned CNT_MAX = (N > TIMEOUT_CYCLES) ? N : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(N);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        WAIT,
        RESP
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        last_grant_q, last_grant_d;
    logic [DATA_BIT_WIDTH-1:0]   conv_X_q, conv_X_d;
    logic                        resp_id_q, resp_id_d;
    logic [DATA_BIT_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                        resp_err_q, resp_err_d;
    logic                        timeout_err_q, timeout_err_d;

    logic grant0, grant1;
    logic hs0, hs1;

    // last_grant_q == 1 means requester 1 was served last, so requester 0 wins a tie.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    assign req0_ready = ~reset & (state_q == IDLE) & grant0;
    assign req1_ready = ~reset & (state_q == IDLE) & grant1;
    assign hs0        = req0_valid & req0_ready;
    assign hs1        = req1_valid & req1_ready;

    assign conv_reset  = reset | (state_q == CLR);
    assign conv_ready  = ~reset & (state_q == RUN);
    assign conv_X      = conv_X_q;
    assign resp_valid  = ~reset & (state_q == RESP);
    assign resp_id     = resp_id_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_grant_q  <= 1'b1;
            conv_X_q      <= '0;
            resp_id_q     <= 1'b0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            conv_X_q      <= conv_X_d;
            resp_id_q     <= resp_id_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        conv_X_d      = conv_X_q;
        resp_id_d     = resp_id_q;
        resp_data_d   = resp_data_q;
        resp_err_d    = resp_err_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (hs0 || hs1) begin
                    conv_X_d     = hs1 ? req1_data : req0_data;
                    resp_id_d    = hs1;
                    last_grant_d = hs1;
                    cnt_d        = '0;
                    state_d      = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (conv_valid) begin
                    resp_data_d = conv_x;
                    resp_err_d  = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == WAIT_LAST) begin
                    resp_data_d   = '0;
                    resp_err_d    = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_os2ip_arbiter.sv
// Scoreboard bench for os2ip_arbiter: directed jobs push expected results, a monitor
// pops and compares on every response handshake.
module tb_os2ip_arbiter;

    localparam int DW = 256;
    localparam int N  = DW / 8;
    localparam int TO = 16;
    localparam logic [DW-1:0] MASK = {8{32'hA5C3_5A3C}};

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          resp_valid, resp_ready, resp_id, resp_err;
    logic [DW-1:0] resp_data;
    logic          conv_reset, conv_ready;
    logic [DW-1:0] conv_X;
    logic [DW-1:0] conv_x = '0;
    logic          conv_valid = 1'b0;
    logic          busy, timeout_err;

    always #5 clk = ~clk;

    os2ip_arbiter #(.DATA_BIT_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err),
        .conv_reset(conv_reset), .conv_ready(conv_ready), .conv_X(conv_X),
        .conv_x(conv_x), .conv_valid(conv_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Converter model: shifts in one octet per ready cycle (MSB first), answers on the
    // (N+1)th ready cycle; the result is masked so it differs from the operand.
    logic [DW-1:0] acc = '0;
    int            ccnt = 0;
    bit            conv_en = 1'b1;
    bit            inject  = 1'b0;
    always @(posedge clk) begin
        conv_valid <= 1'b0;
        if (conv_reset) begin
            acc  <= '0;
            ccnt <= 0;
        end else if (conv_ready) begin
            if (ccnt < N) begin
                acc  <= {acc[DW-9:0], conv_X[DW-1-8*ccnt -: 8]};
                ccnt <= ccnt + 1;
            end else if (conv_en) begin
                conv_valid <= 1'b1;
                conv_x     <= acc ^ MASK;
            end
        end
        if (inject && conv_ready) begin
            conv_valid <= 1'b1;
            conv_x     <= ~MASK;
        end
    end

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } exp_t;
    exp_t sbq[$];

    int hs_cyc  = 0;
    int fv_cyc  = 0;
    bit in_resp = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_resp = 1'b0;
        end else begin
            if (req0_valid && req1_valid)
                chk("ready_onehot", DW'(req0_ready & req1_ready), '0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
                hs_cyc = cyc;
            if (resp_valid && !in_resp) begin
                in_resp = 1'b1;
                fv_cyc  = cyc;
            end
            if (resp_valid && resp_ready) begin
                in_resp = 1'b0;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got id %0d data %0h, expected no response",
                             resp_id, resp_data);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_id", DW'(resp_id), DW'(e.id));
                    chk("resp_data", resp_data, e.data);
                    chk("resp_err", DW'(resp_err), DW'(e.err));
                    if (e.lat >= 0)
                        chk("latency", DW'(fv_cyc - hs_cyc), DW'(e.lat));
                end
            end
        end
    end

    function automatic logic [DW-1:0] pat(input int s);
        logic [DW-1:0] v;
        for (int i = 0; i < N; i++) v[DW-1-8*i -: 8] = 8'(s * 7 + i * 13);
        return v;
    endfunction

    function automatic exp_t good(input logic id, input logic [DW-1:0] d);
        exp_t e;
        e.id = id; e.data = d ^ MASK; e.err = 1'b0; e.lat = N + 4;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that completes the handshake.
    task automatic send(input int k, input logic [DW-1:0] d);
        bit got = 1'b0;
        if (k == 0) begin req0_valid = 1'b1; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_data = d; end
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (k == 0) got = req0_valid && req0_ready;
            else        got = req1_valid && req1_ready;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: requester %0d got no ready, expected handshake", k);
        end
        @(posedge clk); #1;
    endtask

    task automatic drop(input int k);
        if (k == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            done = (sbq.size() == 0) && !busy;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_conv_ready();
        bit seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = conv_ready;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL conv_ready_timeout: conv_ready never rose, expected RUN");
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;
        bit   seen;
        logic [DW-1:0] d1;

        reset = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;

        // Reset behaviour
        @(posedge clk); #1;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("rst_req0_ready", DW'(req0_ready), '0);
        chk("rst_conv_reset", DW'(conv_reset), DW'(1));
        chk("rst_conv_ready", DW'(conv_ready), '0);
        @(posedge clk); #1;
        req0_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_resp_valid", DW'(resp_valid), '0);
        chk("rst_resp_id", DW'(resp_id), '0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_resp_err", DW'(resp_err), '0);
        chk("rst_conv_X", conv_X, '0);
        chk("rst_timeout_err", DW'(timeout_err), '0);
        chk("rst_conv_reset_rel", DW'(conv_reset), '0);
        @(posedge clk); #1;

        // Single job, operand 0x0102..20
        for (int i = 0; i < N; i++) d1[DW-1-8*i -: 8] = 8'(i + 1);
        sbq.push_back(good(1'b0, d1));
        send(0, d1);
        drop(0);
        drain();
        chk("conv_X_hold", conv_X, d1);

        // Both requesters valid from reset: order 0,1,0,1
        pulse_reset();
        sbq.push_back(good(1'b0, pat(1)));
        sbq.push_back(good(1'b1, pat(2)));
        sbq.push_back(good(1'b0, pat(3)));
        sbq.push_back(good(1'b1, pat(4)));
        fork
            begin send(0, pat(1)); send(0, pat(3)); drop(0); end
            begin send(1, pat(2)); send(1, pat(4)); drop(1); end
        join
        drain();

        // Converter never answers: timeout, then sticky flag survives a good job
        conv_en = 1'b0;
        e.id = 1'b0; e.data = '0; e.err = 1'b1; e.lat = N + 3 + TO;
        sbq.push_back(e);
        send(0, pat(5));
        drop(0);
        drain();
        chk("timeout_err_set", DW'(timeout_err), DW'(1));
        conv_en = 1'b1;
        sbq.push_back(good(1'b1, pat(6)));
        send(1, pat(6));
        drop(1);
        drain();
        chk("timeout_err_sticky", DW'(timeout_err), DW'(1));

        // Back-pressure: response held 10 cycles, pending request not accepted
        resp_ready = 1'b0;
        sbq.push_back(good(1'b0, pat(7)));
        sbq.push_back(good(1'b1, pat(8)));
        send(0, pat(7));
        drop(0);
        req1_valid = 1'b1; req1_data = pat(8);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        chk("stall_resp_seen", DW'(seen), DW'(1));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_resp_valid", DW'(resp_valid), DW'(1));
            chk("stall_resp_data", resp_data, pat(7) ^ MASK);
            chk("stall_req1_ready", DW'(req1_ready), '0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        send(1, pat(8));
        drop(1);
        drain();

        // Reset in the middle of RUN abandons the job
        send(0, pat(9));
        drop(0);
        wait_conv_ready();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_conv_reset", DW'(conv_reset), DW'(1));
        chk("midrst_conv_ready", DW'(conv_ready), '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", DW'(busy), '0);
        chk("midrst_conv_ready_after", DW'(conv_ready), '0);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("midrst_no_resp", DW'(seen), '0);
        @(posedge clk); #1;
        sbq.push_back(good(1'b0, pat(10)));
        send(0, pat(10));
        drop(0);
        drain();

        // Spurious conv_valid during RUN is ignored
        sbq.push_back(good(1'b1, pat(11)));
        send(1, pat(11));
        drop(1);
        wait_conv_ready();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
